// File: rtl/clkdiv_multi_if.sv
// Divisor-load port for clkdiv_multi: a valid/ready request carrying a
// target channel and a new divisor. The requester drives the master side.
interface clkdiv_multi_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 16
) ();
  logic             ld_valid;
  logic [CH_W-1:0]  ld_ch;
  logic [CNT_W-1:0] ld_div;
  logic             ld_ready;

  modport master (output ld_valid, ld_ch, ld_div, input  ld_ready);
  modport slave  (input  ld_valid, ld_ch, ld_div, output ld_ready);
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable generator with runtime-programmable divisors.
// Each channel emits a one-cycle tick every D enabled cycles (D = 0 disables
// the channel). New divisors arrive through a single-entry load slot and are
// applied at the target's next wrap, so a period is never cut short.
// Optional build macro: CLKDIV_PHASE_OUT_EN adds a 50 % duty phase output per
// channel; without it the phase port is tied to zero.
module clkdiv_multi #(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd32768, 16'd2}
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  clkdiv_multi_if.slave       ld,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   phase
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] div [NUM_CH];
  logic [NUM_CH-1:0] tick_q;

  logic             pend_v;
  logic [CH_W-1:0]  pend_ch;
  logic [CNT_W-1:0] pend_div;

  logic [NUM_CH-1:0] wrap;     // channel reaches terminal count this edge
  logic [NUM_CH-1:0] apply;    // pending divisor lands on this channel now
  logic              pend_drop;

  assign ld.ld_ready = !pend_v;
  assign tick        = tick_q;

  // Wrap detection and pending-apply decode for every channel.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    wrap      = '0;
    apply     = '0;
    pend_drop = pend_v && (int'(pend_ch) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = en && (div[i] != '0) && (cnt[i] == div[i] - 1'b1);
      apply[i] = pend_v && (int'(pend_ch) == i) && ((div[i] == '0) || wrap[i]);
    end
  end

  // Per-channel counter, divisor and tick registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: cnt/div are small per-channel flop arrays, not RAM, so clearing
      // them in reset is cheap and gives every channel a known phase.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div[i] == '0) begin
          cnt[i]    <= '0;
          tick_q[i] <= 1'b0;
        end else if (en) begin
          // NOTE: non-blocking assignments keep every register sampling the
          // pre-edge values, so the order of these statements does not matter.
          if (wrap[i]) begin
            cnt[i]    <= '0;
            tick_q[i] <= 1'b1;
          end else begin
            cnt[i]    <= cnt[i] + 1'b1;
            tick_q[i] <= 1'b0;
          end
        end else begin
          tick_q[i] <= 1'b0;
        end
        // The wrap tick above still belongs to the old period; the new
        // divisor governs the period that starts at cnt = 0.
        if (apply[i]) div[i] <= pend_div;
      end
    end
  end

  // Single-entry load slot: capture when free, release on apply or discard.
  always_ff @(posedge clk) begin
    if (clr) begin
      pend_v <= 1'b0;
    end else if (pend_v) begin
      if (pend_drop || (|apply)) pend_v <= 1'b0;
    end else if (ld.ld_valid) begin
      pend_v   <= 1'b1;
      pend_ch  <= ld.ld_ch;
      pend_div <= ld.ld_div;
    end
  end

`ifdef CLKDIV_PHASE_OUT_EN
  logic [NUM_CH-1:0] phase_q;

  // Phase flips on every tick, giving a square wave of period 2D.
  always_ff @(posedge clk) begin
    if (clr) phase_q <= '0;
    else     phase_q <= phase_q ^ wrap;
  end

  assign phase = phase_q;
`else
  assign phase = '0;
`endif

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi: three channels so that an out-of-range channel
// number is representable. A cycle-level reference model predicts tick,
// phase and ld_ready after every edge from enabled-edge timestamps; a monitor
// compares the DUT against those predictions on the falling edge.
module tb_clkdiv_multi;

  localparam int N     = 3;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;
  localparam logic [N*CNT_W-1:0] INIT = {16'd7, 16'd32768, 16'd2};

  logic clk = 1'b0;
  logic clr;
  logic en;
  logic [N-1:0] tick;
  logic [N-1:0] phase;

  clkdiv_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) ld_if ();

  clkdiv_multi #(.NUM_CH(N), .CNT_W(CNT_W), .DIV_INIT(INIT)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .ld    (ld_if.slave),
    .tick  (tick),
    .phase (phase)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [N-1:0] tick;
    logic [N-1:0] phase;
    logic         ready;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel remembers the enabled-edge number at which its next tick is
  // due; a tick fires when the global enabled-edge count reaches it.
  logic [CNT_W-1:0] m_div [N];
  longint           m_due [N];
  longint           m_ecnt;
  bit               m_pv;
  int               m_pch;
  logic [CNT_W-1:0] m_pdiv;
  logic [N-1:0]     m_phase;

  initial begin
    exp_t e;
    bit pv_old;
    logic [N-1:0] wr;
    m_pv = 1'b0;
    forever begin
      @(posedge clk);
      wr = '0;
      if (clr) begin
        m_ecnt  = 0;
        m_pv    = 1'b0;
        m_phase = '0;
        for (int i = 0; i < N; i++) begin
          m_div[i] = INIT[i*CNT_W +: CNT_W];
          m_due[i] = longint'(m_div[i]);
        end
      end else begin
        pv_old = m_pv;
        if (en) m_ecnt++;
        for (int i = 0; i < N; i++)
          if (en && m_div[i] != 0 && m_ecnt == m_due[i]) wr[i] = 1'b1;
        m_phase ^= wr;
        if (pv_old) begin
          if (m_pch >= N) begin
            m_pv = 1'b0;
          end else if (m_div[m_pch] == 0) begin
            m_div[m_pch] = m_pdiv;
            m_due[m_pch] = m_ecnt + longint'(m_pdiv);
            m_pv = 1'b0;
          end else if (wr[m_pch]) begin
            m_div[m_pch] = m_pdiv;
            m_pv = 1'b0;
          end
        end
        for (int i = 0; i < N; i++)
          if (wr[i]) m_due[i] = m_ecnt + longint'(m_div[i]);
        if (!pv_old && ld_if.ld_valid) begin
          m_pv   = 1'b1;
          m_pch  = int'(ld_if.ld_ch);
          m_pdiv = ld_if.ld_div;
        end
      end
      e.tick = wr;
`ifdef CLKDIV_PHASE_OUT_EN
      e.phase = m_phase;
`else
      e.phase = '0;
`endif
      e.ready = !m_pv;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick",     32'(tick),            32'(e.tick));
        check("phase",    32'(phase),           32'(e.phase));
        check("ld_ready", 32'(ld_if.ld_ready),  32'(e.ready));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Requester holds the request until it observes ready before an edge.
  task automatic load(input int ch, input int d);
    bit done = 1'b0;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_ch    = CH_W'(ch);
    ld_if.ld_div   = CNT_W'(d);
    for (int k = 0; k < 1000 && !done; k++) begin
      if (ld_if.ld_ready) done = 1'b1;
      @(negedge clk);
    end
    ld_if.ld_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL load_timeout: ld_ready stayed 0 for ch %0d, required 1 within 1000 cycles", ch);
    end
  endtask

  // One-cycle request regardless of ready; ignored if the slot is busy.
  task automatic poke(input int ch, input int d);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_ch    = CH_W'(ch);
    ld_if.ld_div   = CNT_W'(d);
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    en  = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_ch    = '0;
    ld_if.ld_div   = '0;
    cycles(3);
    clr = 1'b0;
    en  = 1'b1;

    // Reset divisors: ch0 every 2, ch2 every 7, ch1 first at edge 32768.
    cycles(32760);
    // Disable ch1 (applies at its first wrap), then re-enable with D=3.
    load(1, 0);
    cycles(20);
    load(1, 3);
    cycles(20);

    // Runtime reload of ch0 from 2 to 5.
    load(0, 5);
    cycles(30);

    // Global freeze for 10 cycles.
    cycles(2);
    en = 1'b0;
    cycles(10);
    en = 1'b1;
    cycles(20);

    // Second request while the slot is busy is ignored.
    load(2, 9);
    poke(0, 1);
    cycles(25);

    // Out-of-range channel is discarded.
    poke(3, 4);
    cycles(5);

    // Phase square wave on ch0 with D=4; ch2 at D=1.
    load(0, 4);
    load(2, 1);
    cycles(40);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          en = 1'b1;
          load($urandom_range(0, 3), $urandom_range(0, 12));
        end
        1: poke($urandom_range(0, 3), $urandom_range(0, 12));
        default: en = ($urandom_range(0, 4) != 0);
      endcase
      cycles($urandom_range(1, 8));
    end

    // Reset with a load pending: ch2 gets a long period, then a second
    // load sits pending when clr arrives and must be lost.
    en = 1'b1;
    load(2, 50);
    load(2, 5);
    cycles(2);
    clr = 1'b1;
    cycles(2);
    clr = 1'b0;
    cycles(40);

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
